bound_flasher_monitor: RTL and testbench
========================================

# bound_flasher_monitor

Receive-side decoder for the 16-lamp bound-flasher output bus. Samples `lamps_in` each enabled cycle, converts the thermometer pattern to a lamp level, and tracks the six-phase flash sequence (up to 16, down to 5, up to 11, down to 0, up to 6, down to 0). Reports phase, level, kickback events, completed cycles and protocol errors. Sits beside the flasher as an on-chip checker / status source for downstream logic.

## Interface

Parameters:
- `N_LAMPS`, 16, lamp bus width; level width is clog2(N_LAMPS+1) = 5.
- `CNT_W`, 8, width of the completed-cycle counter.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `lamps_in`  in  N_LAMPS  observed lamp bus; bit 0 lights first.
- `sample_en`  in  1  qualifies `lamps_in` this cycle.
- `level`  out  5  lamps lit (0..16) in the last accepted sample.
- `phase`  out  3  0 = IDLE, 1..6 = UP0, DN1, UP2, DN3, UP4, DN5; 7 = ERR.
- `kick`  out  1  one-cycle pulse on a recognised kickback.
- `cycle_done`  out  1  one-cycle pulse when DN5 reaches level 0.
- `cycles`  out  CNT_W  count of completed cycles; wraps.
- `err`  out  1  sticky error flag.
- `err_code`  out  2  0 none, 1 BAD_SHAPE, 2 BAD_STEP, 3 BAD_DIR; first error is held.

## Operation

- Accepted sample: `sample_en`=1. Non-thermometer `lamps_in` (not 2^n−1) → BAD_SHAPE; `level` keeps its old value.
- delta = new level − `level`. |delta| > 1 → BAD_STEP. delta = 0 → hold the state; no pulses.
- FSM (state targets come from the package):
  - IDLE: +1 → UP0; −1 → BAD_DIR.
  - UP0, UP2, UP4: +1 stays in the state. Reaching the target (16, 11, 6) moves to the next DN state in the same cycle. −1 below the target → BAD_DIR.
  - DN1: −1 stays in the state. Reaching 5 → UP2. +1 → BAD_DIR.
  - DN3: −1 stays in the state. Reaching 0 → UP4. +1 from level 5 → UP2 with `kick`=1. Any other +1 → BAD_DIR.
  - DN5: −1 stays in the state. Reaching 0 → IDLE with `cycle_done`=1 and `cycles`+1 (mod 2^CNT_W). +1 → BAD_DIR.
  - ERR: absorbing until `rst`. `level` keeps tracking valid-shape samples; pulses stay 0.
- On any error: go to ERR, set `err`=1, and latch `err_code` only if it is currently 0.
- Simultaneous events: error checks take priority over the transition and the pulses in the same sample.

## Timing

- All outputs are registered and update on the edge that accepts the sample, so they are visible one cycle after `lamps_in`.
- `kick` and `cycle_done` are high for exactly one cycle. Both are 0 whenever `sample_en`=0.
- Reset values: `level`=0, `phase`=0, `kick`=0, `cycle_done`=0, `cycles`=0, `err`=0, `err_code`=0.
- `rst` mid-sequence clears everything on the next edge. A sample presented in the same cycle as `rst` is discarded.
- `sample_en` may drop for any number of cycles; the state is frozen and the next sample is compared against the last accepted level.

## Structure

- Package `bound_flasher_pkg` contains:
  - the phase enum (3 bits);
  - bound constants UP0_TGT=16, DN1_TGT=5, UP2_TGT=11, DN3_TGT=0, UP4_TGT=6, DN5_TGT=0, KICK_LVL=5;
  - the err_code enum.
- Sub-module `lamp_thermo_decode`: combinational, `lamps_in` → `level_nxt` (5 bits) and `shape_ok`.
- Top level holds the FSM, the error latch and the counter.

## Test plan

- Full clean cycle. Drive level 0→16→5→11→0→6→0 one step per cycle. Expect the phase sequence 1..6→0, exactly one `cycle_done`, `cycles`=1, `err`=0.
- Kickback. Run to DN3 and step down to level 5, then drive level 6. Expect `kick`=1 for one cycle and `phase`=UP2. Continue to 11→0→6→0 and expect `cycle_done` with no error.
- Bad step. From level 3 in UP0, drive 0x001F (level 5). Expect `err`=1, `err_code`=2, `phase`=7. A following bad shape must leave `err_code`=2.
- Bad shape and bad direction:
  - In IDLE, drive `lamps_in`=0x0005. Expect `err_code`=1 and `level` still 0.
  - After reset, in DN1 at level 10, step up to 11. Expect `err_code`=3.
- Gapped and held samples. Hold `sample_en`=0 for 5 cycles mid-UP2, repeat the same level twice, then resume. Expect no error, no pulses, and an unchanged phase.
- Reset mid-operation. Assert `rst` during DN5 at level 3 with `sample_en`=1. Expect all outputs 0 the next cycle, then a clean cycle from IDLE. Also run 256 cycles and check that `cycles` wraps to 0.

Source files
------------

// File: rtl/bound_flasher_pkg.sv
// Shared types and bound constants for the bound-flasher receive-side monitor.
// The phase order and bound table define the six-phase flash sequence.
package bound_flasher_pkg;

    localparam int LVL_W = 5;

    typedef logic [LVL_W-1:0] level_t;

    localparam level_t LVL_ZERO = {LVL_W{1'b0}};
    localparam level_t LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_UP0  = 3'd1,
        PH_DN1  = 3'd2,
        PH_UP2  = 3'd3,
        PH_DN3  = 3'd4,
        PH_UP4  = 3'd5,
        PH_DN5  = 3'd6,
        PH_ERR  = 3'd7
    } phase_e;

    localparam level_t UP0_TGT  = 5'd16;
    localparam level_t DN1_TGT  = 5'd5;
    localparam level_t UP2_TGT  = 5'd11;
    localparam level_t DN3_TGT  = 5'd0;
    localparam level_t UP4_TGT  = 5'd6;
    localparam level_t DN5_TGT  = 5'd0;
    localparam level_t KICK_LVL = 5'd5;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_BAD_SHAPE = 2'd1,
        ERR_BAD_STEP  = 2'd2,
        ERR_BAD_DIR   = 2'd3
    } err_code_e;

    // Level at which a phase hands over to the next one.
    function automatic level_t phase_target(input phase_e ph);
        level_t tgt;
        case (ph)
            PH_UP0:  tgt = UP0_TGT;
            PH_DN1:  tgt = DN1_TGT;
            PH_UP2:  tgt = UP2_TGT;
            PH_DN3:  tgt = DN3_TGT;
            PH_UP4:  tgt = UP4_TGT;
            PH_DN5:  tgt = DN5_TGT;
            default: tgt = LVL_ZERO;
        endcase
        return tgt;
    endfunction

    function automatic phase_e phase_after(input phase_e ph);
        phase_e nxt;
        case (ph)
            PH_IDLE: nxt = PH_UP0;
            PH_UP0:  nxt = PH_DN1;
            PH_DN1:  nxt = PH_UP2;
            PH_UP2:  nxt = PH_DN3;
            PH_DN3:  nxt = PH_UP4;
            PH_UP4:  nxt = PH_DN5;
            PH_DN5:  nxt = PH_IDLE;
            default: nxt = PH_ERR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bound_flasher_monitor_if.sv
// Lamp bus plus decoded status of the bound-flasher monitor.
// master drives the lamps and reads status; slave is the monitor itself.
interface bound_flasher_monitor_if #(
    parameter int N_LAMPS = 16,
    parameter int CNT_W   = 8
) ();

    logic [N_LAMPS-1:0]        lamps_in;
    logic                      sample_en;
    bound_flasher_pkg::level_t level;
    logic [2:0]                phase;
    logic                      kick;
    logic                      cycle_done;
    logic [CNT_W-1:0]          cycles;
    logic                      err;
    logic [1:0]                err_code;

    modport master (
        output lamps_in, sample_en,
        input  level, phase, kick, cycle_done, cycles, err, err_code
    );

    modport slave (
        input  lamps_in, sample_en,
        output level, phase, kick, cycle_done, cycles, err, err_code
    );

endinterface

// File: rtl/bound_flasher_monitor_chk.sv
// Invariants of the monitor's registered outputs, for simulation use alongside it.
module bound_flasher_monitor_chk (
    input logic       clk,
    input logic       rst,
    input logic [2:0] phase,
    input logic       kick,
    input logic       cycle_done,
    input logic       err,
    input logic [1:0] err_code
);

    a_pulses_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(kick && cycle_done))
        else $error("kick and cycle_done high together");

    a_err_phase: assert property (@(posedge clk) disable iff (rst)
        err == (phase == 3'd7))
        else $error("err flag and ERR phase disagree");

    a_err_code: assert property (@(posedge clk) disable iff (rst)
        err == (err_code != 2'd0))
        else $error("err flag and err_code disagree");

    a_kick_phase: assert property (@(posedge clk) disable iff (rst)
        kick |-> (phase == 3'd3))
        else $error("kick outside UP2");

    a_done_phase: assert property (@(posedge clk) disable iff (rst)
        cycle_done |-> (phase == 3'd0))
        else $error("cycle_done outside IDLE");

endmodule

// File: rtl/bound_flasher_monitor_decode.sv
// Thermometer decoder: counts lit lamps and flags patterns that are not 2^n-1.
module lamp_thermo_decode
    import bound_flasher_pkg::*;
#(
    parameter int N_LAMPS = 16
) (
    input  logic [N_LAMPS-1:0] lamps_in,
    output level_t             level_nxt,
    output logic               shape_ok
);

    logic [N_LAMPS-1:0] lamps_inc_s;

    // A thermometer code plus one shares no set bit with itself.
    always_comb begin
        lamps_inc_s = lamps_in + {{(N_LAMPS-1){1'b0}}, 1'b1};
        shape_ok    = ((lamps_in & lamps_inc_s) == {N_LAMPS{1'b0}});
        level_nxt   = LVL_ZERO;
        for (int i = 0; i < N_LAMPS; i++) begin
            level_nxt = level_nxt + level_t'(lamps_in[i]);
        end
    end

endmodule

// File: rtl/bound_flasher_monitor.sv
// Receive-side monitor for the bound-flasher lamp bus: tracks the flash phase,
// reports kickbacks, completed cycles and the first protocol error seen.
module bound_flasher_monitor
    import bound_flasher_pkg::*;
#(
    parameter int N_LAMPS = 16,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    bound_flasher_monitor_if.slave bus
);

    level_t            level_nxt_s;
    logic              shape_ok_s;
    logic              step_up_s;
    logic              step_dn_s;
    logic              step_same_s;
    err_code_e         err_new_s;

    phase_e            phase_q, phase_d;
    level_t            level_q, level_d;
    logic              kick_q, kick_d;
    logic              cdone_q, cdone_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              err_q, err_d;
    err_code_e         err_code_q, err_code_d;

    lamp_thermo_decode #(
        .N_LAMPS (N_LAMPS)
    ) u_decode (
        .lamps_in  (bus.lamps_in),
        .level_nxt (level_nxt_s),
        .shape_ok  (shape_ok_s)
    );

    // Classify the new level relative to the last accepted one.
    always_comb begin
        step_same_s = (level_nxt_s == level_q);
        step_up_s   = (level_nxt_s == (level_q + LVL_ONE));
        step_dn_s   = ((level_nxt_s + LVL_ONE) == level_q);
    end

    // Next-state, pulse and error-latch logic for one accepted sample.
    always_comb begin
        phase_d    = phase_q;
        level_d    = level_q;
        kick_d     = 1'b0;
        cdone_d    = 1'b0;
        cycles_d   = cycles_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        err_new_s  = ERR_NONE;

        if (bus.sample_en) begin
            if (!shape_ok_s) begin
                err_new_s = ERR_BAD_SHAPE;
            end else begin
                level_d = level_nxt_s;
                if ((phase_q == PH_ERR) || step_same_s) begin
                    phase_d = phase_q;
                end else if (!step_up_s && !step_dn_s) begin
                    err_new_s = ERR_BAD_STEP;
                end else begin
                    case (phase_q)
                        PH_IDLE: begin
                            if (step_up_s) begin
                                phase_d = PH_UP0;
                            end else begin
                                err_new_s = ERR_BAD_DIR;
                            end
                        end
                        PH_UP0, PH_UP2, PH_UP4: begin
                            if (!step_up_s) begin
                                err_new_s = ERR_BAD_DIR;
                            end else if (level_nxt_s == phase_target(phase_q)) begin
                                phase_d = phase_after(phase_q);
                            end else begin
                                phase_d = phase_q;
                            end
                        end
                        PH_DN1, PH_DN3, PH_DN5: begin
                            if (step_dn_s) begin
                                if (level_nxt_s == phase_target(phase_q)) begin
                                    phase_d = phase_after(phase_q);
                                    if (phase_q == PH_DN5) begin
                                        cdone_d  = 1'b1;
                                        cycles_d = cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
                                    end else begin
                                        cdone_d  = 1'b0;
                                    end
                                end else begin
                                    phase_d = phase_q;
                                end
                            end else if ((phase_q == PH_DN3) && (level_q == KICK_LVL)) begin
                                // Kickback: DN3 bounces back up from the DN1 floor.
                                phase_d = PH_UP2;
                                kick_d  = 1'b1;
                            end else begin
                                err_new_s = ERR_BAD_DIR;
                            end
                        end
                        default: begin
                            phase_d = phase_q;
                        end
                    endcase
                end
            end
        end else begin
            phase_d = phase_q;
        end

        // An error overrides whatever transition or pulse was computed above.
        if (err_new_s != ERR_NONE) begin
            phase_d  = PH_ERR;
            err_d    = 1'b1;
            kick_d   = 1'b0;
            cdone_d  = 1'b0;
            cycles_d = cycles_q;
            if (err_code_q == ERR_NONE) begin
                err_code_d = err_new_s;
            end else begin
                err_code_d = err_code_q;
            end
        end else begin
            err_d = err_q;
        end
    end

    // State, counter and error latch; a sample seen during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= PH_IDLE;
            level_q    <= LVL_ZERO;
            kick_q     <= 1'b0;
            cdone_q    <= 1'b0;
            cycles_q   <= {CNT_W{1'b0}};
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            phase_q    <= phase_d;
            level_q    <= level_d;
            kick_q     <= kick_d;
            cdone_q    <= cdone_d;
            cycles_q   <= cycles_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.level      = level_q;
    assign bus.phase      = phase_q;
    assign bus.kick       = kick_q;
    assign bus.cycle_done = cdone_q;
    assign bus.cycles     = cycles_q;
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_bound_flasher_monitor.sv
// Bench for bound_flasher_monitor: directed scenarios plus random traffic,
// all outputs compared each cycle against a sequence-level reference model.
module tb_bound_flasher_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bound_flasher_monitor_if #(.N_LAMPS(16), .CNT_W(8)) bus ();

    bound_flasher_monitor #(.N_LAMPS(16), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bound_flasher_monitor_chk chk (
        .clk        (clk),
        .rst        (rst),
        .phase      (bus.phase),
        .kick       (bus.kick),
        .cycle_done (bus.cycle_done),
        .err        (bus.err),
        .err_code   (bus.err_code)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cdone_seen = 0;

    // Reference model: phase index 0..6 (7 = error) and the level each phase ends at.
    int m_level, m_phase, m_cycles, m_err, m_code, m_kick, m_cdone;
    int bounds [7] = '{0, 16, 5, 11, 0, 6, 0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] th(input int n);
        logic [16:0] t;
        t = (17'd1 << n) - 17'd1;
        return t[15:0];
    endfunction

    function automatic int lit_count(input logic [15:0] v);
        for (int n = 0; n <= 16; n++) begin
            if (v == th(n)) return n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_level = 0; m_phase = 0; m_cycles = 0;
        m_err = 0; m_code = 0; m_kick = 0; m_cdone = 0;
    endtask

    task automatic model_raise(input int code);
        m_phase = 7;
        m_err   = 1;
        if (m_code == 0) m_code = code;
    endtask

    task automatic model_step(input logic [15:0] lamps, input logic en);
        int n, d;
        m_kick  = 0;
        m_cdone = 0;
        if (!en) return;
        n = lit_count(lamps);
        if (n < 0) begin
            model_raise(1);
            return;
        end
        d = n - m_level;
        m_level = n;
        if (m_phase == 7 || d == 0) return;
        if (d > 1 || d < -1) begin
            model_raise(2);
            return;
        end
        if (m_phase == 0) begin
            if (d == 1) m_phase = 1;
            else model_raise(3);
            return;
        end
        // Odd phases climb, even phases fall.
        if ((d == 1) == (m_phase % 2 == 1)) begin
            if (n == bounds[m_phase]) begin
                m_phase = (m_phase + 1) % 7;
                if (m_phase == 0) begin
                    m_cdone  = 1;
                    m_cycles = (m_cycles + 1) % 256;
                end
            end
        end else if (m_phase == 4 && n == 6) begin
            m_phase = 3;
            m_kick  = 1;
        end else begin
            model_raise(3);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".level"},      32'(bus.level),      32'(m_level));
        check_eq({tag, ".phase"},      32'(bus.phase),      32'(m_phase));
        check_eq({tag, ".kick"},       32'(bus.kick),       32'(m_kick));
        check_eq({tag, ".cycle_done"}, 32'(bus.cycle_done), 32'(m_cdone));
        check_eq({tag, ".cycles"},     32'(bus.cycles),     32'(m_cycles));
        check_eq({tag, ".err"},        32'(bus.err),        32'(m_err));
        check_eq({tag, ".err_code"},   32'(bus.err_code),   32'(m_code));
    endtask

    task automatic apply(input string tag, input logic [15:0] lamps, input logic en, input logic do_rst);
        @(negedge clk);
        bus.lamps_in  = lamps;
        bus.sample_en = en;
        rst           = do_rst;
        @(posedge clk);
        if (do_rst) model_reset();
        else model_step(lamps, en);
        #1;
        if (bus.cycle_done) cdone_seen++;
        check_all(tag);
    endtask

    task automatic do_reset();
        apply("reset", 16'h0000, 1'b0, 1'b1);
    endtask

    task automatic walk_to(input string tag, input int target);
        while (m_level != target) begin
            apply(tag, th(m_level + ((target > m_level) ? 1 : -1)), 1'b1, 1'b0);
        end
    endtask

    task automatic run_cycle(input string tag);
        walk_to(tag, 16); walk_to(tag, 5); walk_to(tag, 11);
        walk_to(tag, 0);  walk_to(tag, 6); walk_to(tag, 0);
    endtask

    initial begin
        bus.lamps_in  = 16'h0000;
        bus.sample_en = 1'b0;
        model_reset();
        do_reset();
        do_reset();
        check_eq("reset.phase_zero", 32'(bus.phase), 32'd0);

        // Full clean cycle.
        cdone_seen = 0;
        run_cycle("clean");
        check_eq("clean.done_count", 32'(cdone_seen), 32'd1);
        check_eq("clean.cycles", 32'(bus.cycles), 32'd1);
        check_eq("clean.err", 32'(bus.err), 32'd0);

        // Kickback from level 5 in DN3.
        walk_to("kick", 16); walk_to("kick", 5); walk_to("kick", 11); walk_to("kick", 5);
        apply("kick", th(6), 1'b1, 1'b0);
        check_eq("kick.pulse", 32'(bus.kick), 32'd1);
        check_eq("kick.phase", 32'(bus.phase), 32'd3);
        apply("kick_gap", th(6), 1'b0, 1'b0);
        check_eq("kick.one_cycle", 32'(bus.kick), 32'd0);
        walk_to("kick", 11); walk_to("kick", 0); walk_to("kick", 6); walk_to("kick", 0);
        check_eq("kick.cycles", 32'(bus.cycles), 32'd2);
        check_eq("kick.err", 32'(bus.err), 32'd0);

        // Bad step, then a bad shape must not overwrite the first code.
        do_reset();
        walk_to("step", 3);
        apply("step", 16'h001F, 1'b1, 1'b0);
        check_eq("step.code", 32'(bus.err_code), 32'd2);
        check_eq("step.phase", 32'(bus.phase), 32'd7);
        apply("step_shape", 16'h0005, 1'b1, 1'b0);
        check_eq("step.code_held", 32'(bus.err_code), 32'd2);

        // Bad shape in IDLE.
        do_reset();
        apply("shape", 16'h0005, 1'b1, 1'b0);
        check_eq("shape.code", 32'(bus.err_code), 32'd1);
        check_eq("shape.level", 32'(bus.level), 32'd0);

        // Bad direction in DN1.
        do_reset();
        walk_to("dir", 16); walk_to("dir", 10);
        apply("dir", th(11), 1'b1, 1'b0);
        check_eq("dir.code", 32'(bus.err_code), 32'd3);

        // Gaps and held samples mid-UP2.
        do_reset();
        walk_to("gap", 16); walk_to("gap", 5); walk_to("gap", 8);
        for (int i = 0; i < 5; i++) apply("gap_idle", 16'($urandom), 1'b0, 1'b0);
        apply("gap_hold", th(8), 1'b1, 1'b0);
        apply("gap_hold", th(8), 1'b1, 1'b0);
        check_eq("gap.phase", 32'(bus.phase), 32'd3);
        walk_to("gap", 11); walk_to("gap", 0); walk_to("gap", 6); walk_to("gap", 0);
        check_eq("gap.cycles", 32'(bus.cycles), 32'd1);

        // Reset during DN5 with a live sample, then a clean cycle.
        do_reset();
        walk_to("mid", 16); walk_to("mid", 5); walk_to("mid", 11);
        walk_to("mid", 0); walk_to("mid", 6); walk_to("mid", 3);
        apply("mid_rst", th(2), 1'b1, 1'b1);
        check_eq("mid.level", 32'(bus.level), 32'd0);
        check_eq("mid.phase", 32'(bus.phase), 32'd0);
        check_eq("mid.cycles", 32'(bus.cycles), 32'd0);
        run_cycle("mid_after");
        check_eq("mid.after_cycles", 32'(bus.cycles), 32'd1);

        // 255 more cycles wrap the counter.
        for (int c = 0; c < 255; c++) run_cycle("wrap");
        check_eq("wrap.cycles", 32'(bus.cycles), 32'd0);
        check_eq("wrap.err", 32'(bus.err), 32'd0);

        // Random traffic: mostly legal steps, with gaps, holds, faults and resets.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            int r, nl;
            logic up;
            r = int'($urandom_range(0, 99));
            if (m_phase == 7) begin
                if (r < 20) do_reset();
                else apply("rnd_err", th(int'($urandom_range(0, 16))), 1'($urandom), 1'b0);
            end else if (r < 1) begin
                do_reset();
            end else if (r < 15) begin
                apply("rnd_gap", 16'($urandom), 1'b0, 1'b0);
            end else if (r < 25) begin
                apply("rnd_hold", th(m_level), 1'b1, 1'b0);
            end else if (r < 27) begin
                apply("rnd_jump", th(int'($urandom_range(0, 16))), 1'b1, 1'b0);
            end else if (r < 28) begin
                apply("rnd_junk", 16'($urandom), 1'b1, 1'b0);
            end else begin
                up = (m_phase == 0) || (m_phase % 2 == 1);
                if (m_phase == 4 && m_level == 5 && $urandom_range(0, 2) == 0) up = 1'b1;
                nl = up ? m_level + 1 : m_level - 1;
                if (nl < 0) nl = 0;
                if (nl > 16) nl = 16;
                apply("rnd_step", th(nl), 1'b1, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
